// File: rtl/score_draw_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : score_draw_sequencer
//  Purpose  : Keeps the on-screen BCD score in step with the score counter.
//             Forwards increment requests to the counter, snapshots the
//             settled BCD value and issues one sprite draw per digit
//             (most-significant first) over the engine's draw/ready
//             handshake. Leading zeros are drawn as a blank glyph so that
//             stale digits are erased.
//  Revision : 1.0  initial release
// ============================================================================
module score_draw_sequencer #(
   parameter int          SCORE_BITWIDTH = 24,
   parameter logic [15:0] X_ORIGIN       = 16'd10,
   parameter logic [15:0] Y_ORIGIN       = 16'd10,
   parameter logic [15:0] DIGIT_PITCH    = 16'd12,
   parameter logic [7:0]  MIF_BASE       = 8'd0
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      scoreIncrement,
   input  logic                      refresh,
   output logic                      counterEnable,
   input  logic [SCORE_BITWIDTH-1:0] countValue,
   input  logic                      drawReady,
   output logic                      draw,
   output logic [15:0]               xOrigin,
   output logic [15:0]               yOrigin,
   output logic [7:0]                mifId,
   output logic                      busy
);

   localparam int NUM_DIGITS = SCORE_BITWIDTH / 4;
   localparam int IW         = $clog2(NUM_DIGITS + 1);

   localparam logic [IW-1:0] c_LAST  = IW'(NUM_DIGITS - 1);
   localparam logic [7:0]    c_BLANK = MIF_BASE + 8'd10;

   localparam logic [2:0] c_IDLE   = 3'd0;
   localparam logic [2:0] c_SETTLE = 3'd1;
   localparam logic [2:0] c_LATCH  = 3'd2;
   localparam logic [2:0] c_REQ    = 3'd3;
   localparam logic [2:0] c_ACK    = 3'd4;
   localparam logic [2:0] c_DONE   = 3'd5;

   logic [2:0]                r_state;
   logic                      r_ce;
   logic                      r_dirty;
   logic [SCORE_BITWIDTH-1:0] r_snap;
   logic [IW-1:0]             r_idx;
   logic                      r_lz;
   logic [15:0]               r_xacc;
   logic                      r_draw;
   logic [15:0]               r_x;
   logic [15:0]               r_y;
   logic [7:0]                r_mif;
   logic                      r_busy;

   logic [3:0]                w_nib;
   logic [7:0]                w_mif;
   logic                      w_lz_next;

   // The snapshot is shifted left after each digit, so the current digit
   // always sits in the top nibble.
   assign w_nib = r_snap[SCORE_BITWIDTH-1 -: 4];

   // Glyph selection: invalid BCD and leading zeros become blank; the last
   // digit is always shown so a zero score still reads "0".
   always_comb begin
      w_mif     = c_BLANK;
      w_lz_next = r_lz;
      if (w_nib > 4'd9) begin
         w_lz_next = 1'b0;
      end else if (r_lz && (w_nib == 4'd0) && (r_idx != c_LAST)) begin
         w_lz_next = 1'b1;
      end else begin
         w_mif     = MIF_BASE + {4'd0, w_nib};
         w_lz_next = 1'b0;
      end
   end

   // Increment requests are forwarded one-for-one, independent of the sweep.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_ce <= 1'b0;
      end else begin
         r_ce <= scoreIncrement;
      end
   end

   // Dirty marks a pending redraw; set out of reset so the first score shows.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_dirty <= 1'b1;
      end else if (r_ce || refresh) begin
         r_dirty <= 1'b1;
      end else if (r_state == c_LATCH) begin
         r_dirty <= 1'b0;
      end
   end

   // Sweep sequencer: settle, snapshot, then one handshake per digit.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= c_IDLE;
         r_snap  <= '0;
         r_idx   <= '0;
         r_lz    <= 1'b1;
         r_xacc  <= 16'd0;
         r_draw  <= 1'b0;
         r_x     <= 16'd0;
         r_y     <= 16'd0;
         r_mif   <= 8'd0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               // Wait out an enable pulse so the counter has moved first.
               if (r_dirty && !r_ce) begin
                  r_state <= c_SETTLE;
                  r_busy  <= 1'b1;
               end
            end
            c_SETTLE: begin
               r_state <= c_LATCH;
            end
            c_LATCH: begin
               r_snap  <= countValue;
               r_idx   <= '0;
               r_lz    <= 1'b1;
               r_xacc  <= X_ORIGIN;
               r_state <= c_REQ;
            end
            c_REQ: begin
               if (drawReady) begin
                  r_x     <= r_xacc;
                  r_y     <= Y_ORIGIN;
                  r_mif   <= w_mif;
                  r_lz    <= w_lz_next;
                  r_draw  <= 1'b1;
                  r_state <= c_ACK;
               end
            end
            c_ACK: begin
               // Engine dropping ready means it has accepted the request.
               if (!drawReady) begin
                  r_draw  <= 1'b0;
                  r_state <= c_DONE;
               end
            end
            c_DONE: begin
               if (drawReady) begin
                  if (r_idx == c_LAST) begin
                     r_state <= c_IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_idx   <= r_idx + 1'b1;
                     r_snap  <= r_snap << 4;
                     r_xacc  <= r_xacc + DIGIT_PITCH;
                     r_state <= c_REQ;
                  end
               end
            end
            default: begin
               r_state <= c_IDLE;
               r_draw  <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign counterEnable = r_ce;
   assign draw          = r_draw;
   assign xOrigin       = r_x;
   assign yOrigin       = r_y;
   assign mifId         = r_mif;
   assign busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_score_draw_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_score_draw_sequencer
//  Purpose  : Directed self-checking bench for score_draw_sequencer with a
//             behavioural BCD counter and a drawing-engine responder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_score_draw_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        scoreIncrement = 1'b0;
   logic        refresh = 1'b0;
   logic        counterEnable;
   logic [23:0] countValue = 24'h000000;
   logic        drawReady = 1'b1;
   logic        draw;
   logic [15:0] xOrigin;
   logic [15:0] yOrigin;
   logic [7:0]  mifId;
   logic        busy;

   int n_checks = 0;
   int n_pass   = 0;

   // counter model controls
   logic        load_req = 1'b0;
   logic [23:0] load_val = 24'h0;
   int          ce_count = 0;

   // engine model state and log
   int          eng_delay = 0;
   int          eng_cnt   = 0;
   int          viol      = 0;
   int          log_n     = 0;
   logic [15:0] log_x   [64];
   logic [15:0] log_y   [64];
   logic [7:0]  log_mif [64];
   logic [15:0] cap_x, cap_y;
   logic [7:0]  cap_m;

   score_draw_sequencer dut (
      .clock          (clock),
      .reset          (reset),
      .scoreIncrement (scoreIncrement),
      .refresh        (refresh),
      .counterEnable  (counterEnable),
      .countValue     (countValue),
      .drawReady      (drawReady),
      .draw           (draw),
      .xOrigin        (xOrigin),
      .yOrigin        (yOrigin),
      .mifId          (mifId),
      .busy           (busy)
   );

   always #5 clock = ~clock;

   function automatic logic [23:0] bcd_inc(input logic [23:0] v);
      logic [23:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      for (int k = 0; k < 6; k++) begin
         if (carry) begin
            if (r[4*k +: 4] == 4'd9) begin
               r[4*k +: 4] = 4'd0;
            end else begin
               r[4*k +: 4] = r[4*k +: 4] + 4'd1;
               carry = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // BCD counter model
   always @(posedge clock) begin
      if (load_req) countValue <= load_val;
      else if (counterEnable) countValue <= bcd_inc(countValue);
      if (counterEnable === 1'b1) ce_count <= ce_count + 1;
   end

   // Drawing engine model: accepts a request, holds ready low eng_delay
   // extra cycles, and flags any protocol violation seen while busy.
   always @(negedge clock) begin
      if (!reset) begin
         drawReady = 1'b1;
         eng_cnt   = 0;
      end else if (drawReady && draw) begin
         if (log_n < 64) begin
            log_x[log_n]   = xOrigin;
            log_y[log_n]   = yOrigin;
            log_mif[log_n] = mifId;
         end
         log_n++;
         cap_x = xOrigin;
         cap_y = yOrigin;
         cap_m = mifId;
         drawReady = 1'b0;
         eng_cnt   = eng_delay;
      end else if (!drawReady) begin
         if (draw) viol++;
         if (xOrigin != cap_x || yOrigin != cap_y || mifId != cap_m) viol++;
         if (eng_cnt > 0) eng_cnt--;
         else drawReady = 1'b1;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic wait_draws(input int target, input int budget);
      int c;
      c = 0;
      while ((log_n < target || busy !== 1'b0) && c < budget) begin
         @(posedge clock);
         #1;
         c++;
      end
      check_val("draw_count", log_n, target);
      check_val("busy_end", {31'd0, busy}, 32'd0);
   endtask

   // exp holds six expected mifIds, digit 0 in the top byte
   task automatic check_sweep(input int start, input logic [47:0] exp);
      for (int i = 0; i < 6; i++) begin
         if (start + i < 64) begin
            check_val($sformatf("mif[%0d]", start + i), {24'd0, log_mif[start+i]}, {24'd0, exp[47-8*i -: 8]});
            check_val($sformatf("x[%0d]", start + i), {16'd0, log_x[start+i]}, 32'(10 + 12*i));
            check_val($sformatf("y[%0d]", start + i), {16'd0, log_y[start+i]}, 32'd10);
         end
      end
   endtask

   task automatic pulse_refresh();
      @(negedge clock);
      refresh = 1'b1;
      @(negedge clock);
      refresh = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_ce"},   {31'd0, counterEnable}, 32'd0);
      check_val({tag, "_draw"}, {31'd0, draw}, 32'd0);
      check_val({tag, "_x"},    {16'd0, xOrigin}, 32'd0);
      check_val({tag, "_y"},    {16'd0, yOrigin}, 32'd0);
      check_val({tag, "_mif"},  {24'd0, mifId}, 32'd0);
      check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int start;
      int ce0;
      int v0;
      int n;

      // ---- reset state and first sweep of a zero score
      repeat (3) @(posedge clock);
      #1;
      check_reset_outputs("rst");
      @(negedge clock);
      start = log_n;
      reset = 1'b1;
      n = 0;
      while (busy !== 1'b1 && n < 10) begin
         @(posedge clock);
         #1;
         n++;
      end
      n = 0;
      while (draw !== 1'b1 && n < 10) begin
         @(posedge clock);
         #1;
         n++;
      end
      check_val("first_draw_latency", n, 3);
      wait_draws(start + 6, 500);
      check_sweep(start, 48'h0A0A0A0A0A00);

      // ---- single increment
      ce0 = ce_count;
      start = log_n;
      @(negedge clock);
      scoreIncrement = 1'b1;
      @(posedge clock);
      #1;
      scoreIncrement = 1'b0;
      check_val("ce_pulse_high", {31'd0, counterEnable}, 32'd1);
      @(posedge clock);
      #1;
      check_val("ce_pulse_low", {31'd0, counterEnable}, 32'd0);
      wait_draws(start + 6, 500);
      check_sweep(start, 48'h0A0A0A0A0A01);
      check_val("ce_count_inc", ce_count - ce0, 1);

      // ---- refresh with counter at 000907
      @(negedge clock);
      load_val = 24'h000907;
      load_req = 1'b1;
      @(negedge clock);
      load_req = 1'b0;
      ce0 = ce_count;
      start = log_n;
      pulse_refresh();
      wait_draws(start + 6, 500);
      check_sweep(start, 48'h0A0A0A090007);
      check_val("ce_count_refresh", ce_count - ce0, 0);

      // ---- increment while digit 2 is being drawn
      ce0 = ce_count;
      start = log_n;
      pulse_refresh();
      n = 0;
      while (log_n < start + 2 && n < 200) begin
         @(posedge clock);
         #1;
         n++;
      end
      @(negedge clock);
      scoreIncrement = 1'b1;
      @(negedge clock);
      scoreIncrement = 1'b0;
      wait_draws(start + 12, 1000);
      check_sweep(start, 48'h0A0A0A090007);
      check_sweep(start + 6, 48'h0A0A0A090008);
      check_val("ce_count_midsweep", ce_count - ce0, 1);

      // ---- slow engine: ready held low 50 cycles after each draw
      eng_delay = 50;
      v0 = viol;
      start = log_n;
      pulse_refresh();
      wait_draws(start + 6, 2000);
      check_sweep(start, 48'h0A0A0A090008);
      check_val("slow_engine_protocol", viol - v0, 0);

      // ---- reset during ACK of digit 3
      eng_delay = 20;
      start = log_n;
      pulse_refresh();
      n = 0;
      while (log_n < start + 4 && n < 1000) begin
         @(negedge clock);
         #1;
         n++;
      end
      check_val("pre_reset_draw", {31'd0, draw}, 32'd1);
      reset = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      eng_delay = 0;
      repeat (2) @(negedge clock);
      start = log_n;
      #2;
      reset = 1'b1;
      wait_draws(start + 6, 500);
      check_sweep(start, 48'h0A0A0A090008);
      check_val("protocol_total", viol, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/score_draw_sequencer.md
# score_draw_sequencer

Sequences the BCD score counter and the MIF sprite drawing engine so the on-screen score always matches the counter. Forwards score-increment requests to the counter, snapshots its BCD value once settled, then walks the digits most-significant first, issuing one draw request per digit over the engine's draw/ready handshake. Leading zeros are drawn as a blank sprite so stale digits are erased. Sits between game logic, `BCDCounter` and `DrawMif` in the DE1-SoC display path.

## Interface
- `SCORE_BITWIDTH`, 24, counter width; multiple of 4; NUM_DIGITS = SCORE_BITWIDTH/4
- `X_ORIGIN`, 16'd10, x pixel of most-significant digit
- `Y_ORIGIN`, 16'd10, y pixel of all digits
- `DIGIT_PITCH`, 16'd12, x spacing between digit origins
- `MIF_BASE`, 8'd0, mifId of glyph "0"; digit d uses MIF_BASE+d; blank glyph is MIF_BASE+10
- `clock`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `scoreIncrement`  in  1  one-cycle request to add one to the score
- `refresh`  in  1  one-cycle request to redraw without counting
- `counterEnable`  out  1  enable pulse to BCDCounter
- `countValue`  in  SCORE_BITWIDTH  BCD value from BCDCounter
- `drawReady`  in  1  drawing engine idle/ready
- `draw`  out  1  draw request to drawing engine
- `xOrigin`  out  16  sprite x origin
- `yOrigin`  out  16  sprite y origin
- `mifId`  out  8  sprite selector
- `busy`  out  1  high while a redraw sweep is in progress

## Operation
- `counterEnable` = `scoreIncrement` registered; independent of FSM; one pulse per request, no loss or merging.
- `dirty` flag: set by `counterEnable` high or `refresh` high; set at reset (initial score drawn after reset).
- FSM states: IDLE, SETTLE, LATCH, REQ, ACK, DONE.
- IDLE: if `dirty` and `counterEnable` low -> SETTLE. `busy` = 0.
- SETTLE: one cycle for counter output to update -> LATCH.
- LATCH: capture `countValue` into snapshot; clear `dirty` (unless set again this cycle); digit index i = 0; leading-zero flag lz = 1 -> REQ.
- REQ: wait for `drawReady` = 1; then drive `xOrigin` = X_ORIGIN + i*DIGIT_PITCH, `yOrigin` = Y_ORIGIN, `mifId`, assert `draw` -> ACK.
- mifId: digit nibble n (i = 0 is bits [SCORE_BITWIDTH-1 -: 4]); if lz and n == 0 and i != NUM_DIGITS-1 -> MIF_BASE+10, else MIF_BASE+n and lz cleared. Last digit never blank.
- ACK: hold `draw` and coordinates until `drawReady` = 0; then `draw` = 0 -> DONE.
- DONE: wait `drawReady` = 1; if i == NUM_DIGITS-1 -> IDLE, else i+1 -> REQ.
- Increments/refresh during a sweep: sweep finishes with old snapshot; `dirty` causes a full second sweep.
- Nibbles > 9 (invalid BCD): drawn as blank.
- Coordinate arithmetic 16-bit, wraps modulo 2^16.

## Timing
- Reset values: `counterEnable` 0, `draw` 0, `xOrigin` 0, `yOrigin` 0, `mifId` 0, `busy` 0, FSM IDLE, `dirty` 1.
- `counterEnable` rises one cycle after `scoreIncrement`.
- Snapshot taken no earlier than 2 cycles after the last `counterEnable` pulse.
- Idle-to-first-`draw` with engine ready: 3 cycles (SETTLE, LATCH, REQ).
- `draw` asserted only while `drawReady` sampled high; deasserted the cycle after `drawReady` sampled low; never reasserted before `drawReady` returns high.
- Outputs registered; coordinates stable from `draw` rise to `drawReady` fall.
- Reset asserted mid-sweep: all outputs return to reset values immediately; after release full redraw of current `countValue`.
- `busy` high from SETTLE through final DONE exit.

## Test plan
- Reset release, counter 0, engine ready -> 6 draws: mifId 10,10,10,10,10 at x=10,22,34,46,58 then mifId 0 at x=70, y=10; `busy` then 0.
- Single `scoreIncrement` -> exactly one `counterEnable` pulse next cycle; sweep draws 5 blanks then mifId 1 at x=70.
- Counter at 000907 (BCD), `refresh` pulse -> mifIds 10,10,10,9,0,7; no `counterEnable` pulse.
- `scoreIncrement` during digit 2 of a sweep -> sweep completes with old value, second full sweep shows new value; one `counterEnable` pulse total.
- Engine holds `drawReady` low 50 cycles after `draw` -> `draw` drops after first low sample, no new request until ready high, coordinates unchanged during ACK.
- `reset` low during ACK of digit 3 -> `draw`, `busy`, coordinates 0 asynchronously; after release, complete 6-digit sweep.
